// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared constants and types for the elevator front end
// Purpose: button indices, arbiter states, floor/state encodings shared with
//          the controller, and the fixed-priority request selector.
// Ports: none (package).
package elevator_pkg;

  // Button indices into btn_raw / pending
  localparam int UP     = 0;
  localparam int DOWN   = 1;
  localparam int TO_ONE = 2;
  localparam int TO_TWO = 3;

  // Encodings shared with the logic-processing unit
  localparam logic [1:0] FLOOR_1 = 2'd1;
  localparam logic [1:0] FLOOR_2 = 2'd2;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_UP   = 2'd1;
  localparam logic [1:0] ST_DOWN = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  // Highest-priority pending bit: up > down > toOne > toTwo.
  // Later assignments override earlier ones, so the last test wins.
  function automatic logic [1:0] prio_select(input logic [3:0] req);
    logic [1:0] idx;
    idx = 2'(TO_TWO);
    if (req[TO_ONE]) idx = 2'(TO_ONE);
    if (req[DOWN])   idx = 2'(DOWN);
    if (req[UP])     idx = 2'(UP);
    return idx;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - synchronizer, debounce counter and rising-edge pulse
// Purpose: cleans one asynchronous pushbutton into a single-cycle press pulse.
// Ports:
//   clk  in  clock
//   rst  in  synchronous active-high reset
//   raw  in  asynchronous button level
//   rise out one-cycle pulse on a debounced 0->1 transition
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_d <= level;
      // Any sample that agrees with the current level restarts the count,
      // so only an uninterrupted run of differing samples flips the level.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES)) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign rise = level & ~level_d;

endmodule

// File: rtl/elevator_request_encoder.sv
// rtl/elevator_request_encoder.sv - button-to-request front end of the elevator controller
// Purpose: debounces four buttons, latches presses as pending requests and
//          issues them one at a time, holding each until busy acknowledges it.
// Optional feature: define REQ_TIMEOUT_EN to drop requests that are not
//          acknowledged within ACK_TIMEOUT cycles.
// Ports:
//   clk_50mhz  in  sole clock
//   rst        in  synchronous active-high reset
//   btn_raw    in  [3:0] {toTwo, toOne, down, up}, asynchronous
//   start_stop in  issue enable
//   busy       in  controller is servicing a request
//   up/down/toOne/toTwo out registered request levels, at most one high
//   pending    out [3:0] latched requests (LED drive)
//   drop       out one-cycle pulse when a request times out
module elevator_request_encoder
  import elevator_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int ACK_TIMEOUT     = 50_000_000
) (
  input  logic       clk_50mhz,
  input  logic       rst,
  input  logic [3:0] btn_raw,
  input  logic       start_stop,
  input  logic       busy,
  output logic       up,
  output logic       down,
  output logic       toOne,
  output logic       toTwo,
  output logic [3:0] pending,
  output logic       drop
);

  logic [3:0] rise;
  logic [3:0] clr;
  logic [3:0] req;
  logic [1:0] sel;
  logic       expire;
  arb_state_t state;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
      .clk  (clk_50mhz),
      .rst  (rst),
      .raw  (btn_raw[i]),
      .rise (rise[i])
    );
  end

  // The serviced bit is cleared on acceptance or timeout only.
  always_comb begin
    clr = '0;
    if (state == ISSUE && start_stop && (busy || expire)) begin
      clr[sel] = 1'b1;
    end
  end

  // Set wins over clear so a re-press during acceptance is not lost.
  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr) | rise;
    end
  end

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      state <= IDLE;
      req   <= '0;
      sel   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_stop && !busy && (pending != 4'b0000)) begin
            sel   <= prio_select(pending);
            req   <= 4'b0001 << prio_select(pending);
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (!start_stop) begin
            req   <= '0;
            state <= IDLE;
          end else if (busy) begin
            req   <= '0;
            state <= WAIT;
          end else if (expire) begin
            req   <= '0;
            state <= IDLE;
          end
        end
        WAIT: begin
          if (!busy) begin
            state <= IDLE;
          end
        end
        default: begin
          req   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef REQ_TIMEOUT_EN
  logic [31:0] tmo_cnt;
  logic        drop_r;

  // Held at zero outside ISSUE, so it starts from zero on every entry.
  always_ff @(posedge clk_50mhz) begin
    if (rst || state != ISSUE) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 32'd1;
    end
  end

  assign expire = (state == ISSUE) && (tmo_cnt == 32'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      drop_r <= 1'b0;
    end else begin
      drop_r <= (state == ISSUE) && start_stop && !busy && expire;
    end
  end

  assign drop = drop_r;
`else
  // No timeout path: ACK_TIMEOUT is irrelevant and expire is constant low.
  assign expire = 1'b0 & (ACK_TIMEOUT == 0);
  assign drop   = 1'b0;
`endif

  assign up    = req[UP];
  assign down  = req[DOWN];
  assign toOne = req[TO_ONE];
  assign toTwo = req[TO_TWO];

endmodule

// File: tb/tb_elevator_request_encoder.sv
// tb/tb_elevator_request_encoder.sv - self-checking bench for elevator_request_encoder
module tb_elevator_request_encoder;

  logic       clk_50mhz = 1'b0;
  logic       rst;
  logic [3:0] btn_raw;
  logic       start_stop;
  logic       busy;
  logic       up;
  logic       down;
  logic       toOne;
  logic       toTwo;
  logic [3:0] pending;
  logic       drop;
  logic [3:0] reqv;

  int tests = 0;
  int fails = 0;

  always #5 clk_50mhz = ~clk_50mhz;

  elevator_request_encoder #(
    .DEBOUNCE_CYCLES(4),
    .ACK_TIMEOUT(16)
  ) dut (
    .clk_50mhz  (clk_50mhz),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .start_stop (start_stop),
    .busy       (busy),
    .up         (up),
    .down       (down),
    .toOne      (toOne),
    .toTwo      (toTwo),
    .pending    (pending),
    .drop       (drop)
  );

  assign reqv = {toTwo, toOne, down, up};

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_50mhz);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bounded wait for any request output to rise.
  task automatic wait_req();
    int n;
    n = 0;
    while (reqv == 4'b0000 && n < 12) begin
      step(1);
      n++;
    end
  endtask

  // Priority rule: up > down > toOne > toTwo, i.e. lowest set index.
  function automatic int first_set(input logic [3:0] v);
    for (int i = 0; i < 4; i++) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  initial begin
    int         n;
    int         g;
    int         idx;
    logic [3:0] m;
    logic [3:0] model;
    logic [3:0] onehot;

    // Reset with buttons active
    rst = 1'b1; btn_raw = 4'hF; start_stop = 1'b1; busy = 1'b0;
    step(2);
    chk("rst_req", reqv, 4'b0000);
    chk("rst_pending", pending, 4'b0000);
    chk("rst_drop", drop, 1'b0);
    rst = 1'b0; btn_raw = 4'h0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("post_rst_pending", pending, 4'b0000);
    end
    step(4);

    // Clean press on up: edge 0 is the first edge sampling the press
    btn_raw = 4'b0001;
    step(7);
    chk("press_pending_early", pending, 4'b0000);
    btn_raw = 4'b0000;
    step(1);
    chk("press_pending_edge7", pending, 4'b0001);
    chk("press_req_edge7", reqv, 4'b0000);
    step(1);
    chk("press_up_edge8", reqv, 4'b0001);
    step(2);
    busy = 1'b1;
    step(1);
    chk("ack_up_fall", reqv, 4'b0000);
    chk("ack_pending_clear", pending, 4'b0000);
    step(2);
    chk("wait_req_low", reqv, 4'b0000);
    busy = 1'b0;
    step(10);
    chk("quiet_req", reqv, 4'b0000);

    // Bounce on down: 3-cycle pulses with 1-cycle gaps
    for (int i = 0; i < 5; i++) begin
      btn_raw = 4'b0010; step(3);
      btn_raw = 4'b0000; step(1);
    end
    for (int i = 0; i < 12; i++) begin
      step(1);
      chk("bounce_pending", {pending, reqv}, 8'h00);
    end

    // Priority: up and toTwo pressed together
    btn_raw = 4'b1001;
    step(8);
    btn_raw = 4'b0000;
    wait_req();
    chk("prio_first_up", reqv, 4'b0001);
    chk("prio_pending_both", pending, 4'b1001);
    busy = 1'b1;
    step(1);
    chk("prio_up_ack", {pending, reqv}, 8'h80);
    step(2);
    busy = 1'b0;
    wait_req();
    chk("prio_second_totwo", reqv, 4'b1000);
    busy = 1'b1;
    step(1);
    chk("prio_end", {pending, reqv}, 8'h00);
    busy = 1'b0;
    step(10);

    // Timeout on down with busy held low
    btn_raw = 4'b0010;
    step(8);
    btn_raw = 4'b0000;
    wait_req();
    chk("tmo_down_issued", reqv, 4'b0010);
`ifdef REQ_TIMEOUT_EN
    n = 0;
    while (down && n < 40) begin
      step(1);
      n++;
    end
    chk("tmo_len", n, 16);
    chk("tmo_drop_high", drop, 1'b1);
    chk("tmo_pending_clear", pending, 4'b0000);
    step(1);
    chk("tmo_drop_once", drop, 1'b0);
    step(10);
`else
    n = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (down) n++;
    end
    chk("hold_100", n, 100);
    chk("hold_drop", drop, 1'b0);
    busy = 1'b1;
    step(1);
    chk("hold_ack", {pending, reqv}, 8'h00);
    busy = 1'b0;
    step(10);
`endif

    // Disable during ISSUE, re-enable, then reset during WAIT
    btn_raw = 4'b0100;
    step(8);
    btn_raw = 4'b0000;
    wait_req();
    chk("dis_issued", reqv, 4'b0100);
    start_stop = 1'b0;
    step(1);
    chk("dis_req_low", reqv, 4'b0000);
    chk("dis_pending_kept", pending, 4'b0100);
    step(3);
    chk("dis_still_low", reqv, 4'b0000);
    start_stop = 1'b1;
    step(1);
    chk("reissue", reqv, 4'b0100);
    busy = 1'b1;
    step(1);
    chk("reissue_ack", {pending, reqv}, 8'h00);
    btn_raw = 4'b0001;
    step(8);
    btn_raw = 4'b0000;
    step(1);
    chk("wait_latch", {pending, reqv}, 8'h10);
    rst = 1'b1;
    step(1);
    chk("abort_outputs", {pending, reqv, 3'b000, drop}, 12'h000);
    rst = 1'b0;
    busy = 1'b0;
    step(12);
    chk("abort_residual", {pending, reqv}, 8'h00);

    // Randomized rounds against a transaction-level model
    for (int r = 0; r < 12; r++) begin
      m = 4'($urandom_range(1, 15));
      start_stop = 1'b0;
      g = int'($urandom_range(0, 3));
      for (int k = 0; k < g; k++) begin
        btn_raw = 4'($urandom_range(1, 15));
        step(int'($urandom_range(1, 3)));
        btn_raw = 4'b0000;
        step(1);
      end
      btn_raw = m;
      step(8);
      btn_raw = 4'b0000;
      n = 0;
      while (pending != m && n < 10) begin
        step(1);
        n++;
      end
      chk("rnd_latched", pending, m);
      model = m;
      start_stop = 1'b1;
      while (model != 4'b0000) begin
        idx = first_set(model);
        onehot = 4'b0001 << idx;
        wait_req();
        chk("rnd_issue", reqv, onehot);
        if ($urandom_range(0, 1) == 1) begin
          start_stop = 1'b0;
          step(1);
          chk("rnd_dis", {pending, reqv}, {model, 4'b0000});
          step(int'($urandom_range(0, 2)));
          start_stop = 1'b1;
          wait_req();
          chk("rnd_reissue", reqv, onehot);
        end
        busy = 1'b1;
        step(1);
        model[idx] = 1'b0;
        chk("rnd_ack", {pending, reqv}, {model, 4'b0000});
        step(int'($urandom_range(0, 3)));
        busy = 1'b0;
      end
      step(12);
      chk("rnd_idle", {pending, reqv}, 8'h00);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/elevator_request_encoder.md
# elevator_request_encoder

Front end of the two-floor elevator controller: turns raw pushbuttons into the clean, held request levels (`up`, `down`, `toOne`, `toTwo`) that the logic-processing unit consumes. It synchronizes and debounces each button, latches presses as pending requests, and issues them one at a time in fixed priority. Each request is held until the controller signals acceptance through `busy`. It sits between the board buttons and the controller, and also drives the per-button "request pending" LEDs.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive equal samples (20 ms @ 50 MHz) before a debounced level changes.
- `ACK_TIMEOUT`, 50_000_000: cycles an issued request waits for `busy` before being dropped. Used only with `REQ_TIMEOUT_EN`.

Ports (one clock; reset is synchronous and active-high):
- `clk_50mhz`, in, 1: sole clock.
- `rst`, in, 1: synchronous, active-high reset.
- `btn_raw`, in, 4: asynchronous active-high buttons, ordered {toTwo, toOne, down, up}.
- `start_stop`, in, 1: issue enable; while low, nothing is issued.
- `busy`, in, 1: high while the controller services a request (its `led_drive != 0`).
- `up`, `down`, `toOne`, `toTwo`, out, 1 each: registered request levels; at most one is high at a time.
- `pending`, out, 4: latched requests, same bit order as `btn_raw`; drives the pending LEDs.
- `drop`, out, 1: one-cycle pulse when a request times out.

## Operation
- Per button: 2-flop synchronizer, then debounce counter.
  - Counter reloads to 0 whenever the synchronized sample equals the current debounced level.
  - When the counter reaches `DEBOUNCE_CYCLES` with a differing sample, the debounced level flips.
- A debounced rising edge sets the matching `pending` bit. A press on an already-pending button has no effect.
- Arbiter FSM with three states:
  - IDLE:
    - If `start_stop && !busy && pending != 0`: select the highest-priority pending bit (up > down > toOne > toTwo), drive its output high, go to ISSUE.
  - ISSUE:
    - If `!start_stop`: deassert the output, go to IDLE; `pending` is unchanged.
    - Else if `busy`: deassert the output, clear the selected pending bit, go to WAIT.
    - Else if timeout expires: deassert the output, clear the selected bit, pulse `drop`, go to IDLE.
  - WAIT:
    - If `!busy`: go to IDLE.
- New presses are latched in every state, including a re-press of the button currently being serviced.
- When a debounced edge and a clear hit the same bit in the same cycle, set wins.
- Reset values:
  - all request outputs 0, `pending` 0, `drop` 0;
  - FSM in IDLE;
  - debounced levels 0, all counters 0.
- Reset asserted mid-operation aborts everything on the next edge, with no residual requests.

## Timing
- A clean press sampled at edge 0 gives:
  - debounced level high at edge 2+`DEBOUNCE_CYCLES`;
  - `pending` bit at edge 3+`DEBOUNCE_CYCLES`;
  - request output at edge 4+`DEBOUNCE_CYCLES` (FSM in IDLE and enabled).
- Request output falls, and the pending bit clears, one edge after `busy` is first sampled high.
- Back-to-back requests: the next request issues no earlier than one edge after `busy` is sampled low in WAIT.
- Timeout counter:
  - 32-bit, cleared on entry to ISSUE;
  - expires when it reaches `ACK_TIMEOUT - 1` with `busy` still low;
  - `drop` is high for exactly one cycle.
- `start_stop` falling in ISSUE deasserts the output one edge later.

## Configuration
- `REQ_TIMEOUT_EN` defined: the timeout path exists, so requests the controller ignores (e.g. wrong floor) are dropped after `ACK_TIMEOUT` cycles.
- Not defined: no timeout counter; `drop` is tied to 0; an issued request stays held until accepted, `start_stop` goes low, or reset.

## Structure
- Shared `elevator_pkg` holds:
  - button index constants: UP=0, DOWN=1, TO_ONE=2, TO_TWO=3;
  - arbiter state enum: IDLE, ISSUE, WAIT;
  - floor and state encodings shared with the controller: FLOOR_1=1, FLOOR_2=2, ST_IDLE=0, ST_UP=1, ST_DOWN=2.
- Sub-module `btn_debounce` (synchronizer, debounce counter, rising-edge pulse), instantiated four times.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4` and `ACK_TIMEOUT=16`.
- Reset: hold `rst` 2 cycles with buttons active → all outputs 0; no pending bit within 10 cycles after release.
- Clean press: hold `btn_raw[0]` ≥6 cycles, `start_stop=1`, `busy=0` → `pending[0]` at edge 7, `up` at edge 8. Raise `busy` at edge 10 → `up=0`, `pending[0]=0` at edge 11.
- Bounce: 3-cycle pulses separated by 1-cycle gaps → `pending` stays 0.
- Priority: press up and toTwo together → `up` issues first; after a `busy` high/low cycle, `toTwo` issues; `pending` ends at 0.
- Timeout: issue `down` with `busy=0`.
  - With `REQ_TIMEOUT_EN`: `down` falls after 16 cycles, `drop` pulses once, `pending[1]` clears.
  - Without it: `down` stays high for 100 cycles.
- Disable and abort: drop `start_stop` during ISSUE → output 0 next edge, `pending` kept; re-enable → request reissued. Assert `rst` in WAIT → all outputs 0 next edge.
